// File: rtl/nios_sysid_pkg.sv
// ---------------------------------------------------------------------------
// nios_sysid_pkg
// Shared definitions for the system-ID checker and the system-ID slave
// generator, so both sides agree on word addresses and the expected build
// identity from one source.
//
// Contents:
//   sysid_state_t          FSM state encoding for nios_sysid_checker
//   ST_*                   state constants
//   SYSID_ADDR_ID/TS       word addresses of the ID and timestamp words
//   SYSID_DEFAULT_ID/TS    build-time expected identity
//   sysid_word_matches()   equality helper used by the verdict logic
// ---------------------------------------------------------------------------
package nios_sysid_pkg;

  typedef logic [2:0] sysid_state_t;

  // state   | meaning
  // START   | clear verdict, raise busy, launch ID read
  // RD_ID   | reading word 0 (ID), held through waitrequest
  // RD_TS   | reading word 1 (timestamp), held through waitrequest
  // EVAL    | compare captured words against expected values
  // DONE    | verdict valid; wait for recheck
  localparam sysid_state_t ST_START = 3'd0;
  localparam sysid_state_t ST_RD_ID = 3'd1;
  localparam sysid_state_t ST_RD_TS = 3'd2;
  localparam sysid_state_t ST_EVAL  = 3'd3;
  localparam sysid_state_t ST_DONE  = 3'd4;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'hE097_CBDC;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5767_F2DA;

  function automatic logic sysid_word_matches(input logic [31:0] captured,
                                              input logic [31:0] expected);
    return (captured == expected);
  endfunction

endpackage

// File: rtl/nios_avm_read_timer.sv
// ---------------------------------------------------------------------------
// nios_avm_read_timer
// Per-read waitrequest stall counter. Counts cycles in which the current
// read is stalled and flags expiry on the stall cycle that brings the count
// to LIMIT, so the read strobe is high for exactly LIMIT stalled cycles
// before the master gives up. The counter saturates and never wraps.
//
// Ports:
//   i_clock     system clock
//   i_reset     synchronous active-high reset
//   i_clear     restart counting (new read about to begin / no read active)
//   i_enable    current read is stalled this cycle
//   o_expired   this stall cycle reaches LIMIT; abandon the read
// ---------------------------------------------------------------------------
module nios_avm_read_timer #(
  parameter int LIMIT = 256
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT) + 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] FULL = W'(LIMIT);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != FULL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the stall cycle that would make the count equal LIMIT.
  assign o_expired = i_enable && (r_count >= LAST);

endmodule

// File: rtl/nios_sysid_checker.sv
// ---------------------------------------------------------------------------
// nios_sysid_checker
// Avalon-MM read master that reads the system-ID slave (ID at word 0,
// build timestamp at word 1) after reset and on every recheck pulse,
// compares both words against build-time values and latches a verdict.
// sysid_ok gates CPU boot; the flags are also routed to LEDs/debug.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   recheck              single-cycle request to rerun (honoured in DONE only)
//   avm_address/read     Avalon read master outputs (registered)
//   avm_waitrequest      slave stall
//   avm_readdata         slave read data
//   busy / done          check in progress / verdict valid (sticky)
//   sysid_ok             done and every enabled compare matched, no timeout
//   id_mismatch          word 0 differed from EXPECTED_ID
//   ts_mismatch          word 1 differed from EXPECTED_TIMESTAMP (if checked)
//   timeout              a read stalled for TIMEOUT_CYCLES
//   captured_id/ts       last words successfully read
// ---------------------------------------------------------------------------
module nios_sysid_checker
  import nios_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        recheck,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        sysid_ok,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  sysid_state_t r_state;
  logic         r_avm_address;
  logic         r_avm_read;
  logic         r_busy;
  logic         r_done;
  logic         r_sysid_ok;
  logic         r_id_mismatch;
  logic         r_ts_mismatch;
  logic         r_timeout;
  logic [31:0]  r_captured_id;
  logic [31:0]  r_captured_ts;

  logic w_reading;
  logic w_accept;
  logic w_stall;
  logic w_tmr_clear;
  logic w_expired;

  assign w_reading = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_accept  = w_reading && r_avm_read && !avm_waitrequest;
  assign w_stall   = w_reading && r_avm_read &&  avm_waitrequest;

  // Clearing outside the read states and on every accepted word gives each
  // read its own fresh stall budget.
  assign w_tmr_clear = !w_reading || w_accept;

  nios_avm_read_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_read_timer (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_stall),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_START;
      r_avm_address <= SYSID_ADDR_ID;
      r_avm_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sysid_ok    <= 1'b0;
      r_id_mismatch <= 1'b0;
      r_ts_mismatch <= 1'b0;
      r_timeout     <= 1'b0;
      r_captured_id <= '0;
      r_captured_ts <= '0;
    end else begin
      case (r_state)
        ST_START: begin
          r_busy        <= 1'b1;
          r_done        <= 1'b0;
          r_sysid_ok    <= 1'b0;
          r_id_mismatch <= 1'b0;
          r_ts_mismatch <= 1'b0;
          r_timeout     <= 1'b0;
          r_avm_read    <= 1'b1;
          r_avm_address <= SYSID_ADDR_ID;
          r_state       <= ST_RD_ID;
        end

        ST_RD_ID: begin
          if (w_accept) begin
            // Read stays high and moves straight to word 1: no idle gap.
            r_captured_id <= avm_readdata;
            r_avm_address <= SYSID_ADDR_TS;
            r_state       <= ST_RD_TS;
          end else if (w_expired) begin
            r_avm_read <= 1'b0;
            r_timeout  <= 1'b1;
            r_state    <= ST_DONE;
          end
        end

        ST_RD_TS: begin
          if (w_accept) begin
            r_captured_ts <= avm_readdata;
            r_avm_read    <= 1'b0;
            r_state       <= ST_EVAL;
          end else if (w_expired) begin
            r_avm_read <= 1'b0;
            r_timeout  <= 1'b1;
            r_state    <= ST_DONE;
          end
        end

        ST_EVAL: begin
          r_id_mismatch <= !sysid_word_matches(r_captured_id, EXPECTED_ID);
          r_ts_mismatch <= CHECK_TIMESTAMP &&
                           !sysid_word_matches(r_captured_ts, EXPECTED_TIMESTAMP);
          r_state       <= ST_DONE;
        end

        ST_DONE: begin
          if (recheck) begin
            // Drop the old verdict immediately so boot logic never sees a
            // stale done while the new check is starting.
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_sysid_ok    <= 1'b0;
            r_id_mismatch <= 1'b0;
            r_ts_mismatch <= 1'b0;
            r_timeout     <= 1'b0;
            r_state       <= ST_START;
          end else begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_sysid_ok <= !r_id_mismatch && !r_ts_mismatch && !r_timeout;
          end
        end

        default: begin
          r_avm_read <= 1'b0;
          r_state    <= ST_START;
        end
      endcase
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sysid_ok    = r_sysid_ok;
  assign id_mismatch = r_id_mismatch;
  assign ts_mismatch = r_ts_mismatch;
  assign timeout     = r_timeout;
  assign captured_id = r_captured_id;
  assign captured_ts = r_captured_ts;

endmodule

// File: tb/tb_nios_sysid_checker.sv
module tb_nios_sysid_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recheck = 1'b0;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        a_addr, a_read, a_busy, a_done, a_ok, a_idm, a_tsm, a_to;
  logic [31:0] a_cid, a_cts;
  logic        b_addr, b_read, b_busy, b_done, b_ok, b_idm, b_tsm, b_to;
  logic [31:0] b_cid, b_cts;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nios_sysid_checker #(
    .CHECK_TIMESTAMP (1'b1),
    .TIMEOUT_CYCLES  (16)
  ) u_a (
    .clock(clk), .reset(reset), .recheck(recheck),
    .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(waitrequest), .avm_readdata(readdata),
    .busy(a_busy), .done(a_done), .sysid_ok(a_ok),
    .id_mismatch(a_idm), .ts_mismatch(a_tsm), .timeout(a_to),
    .captured_id(a_cid), .captured_ts(a_cts)
  );

  nios_sysid_checker #(
    .CHECK_TIMESTAMP (1'b0),
    .TIMEOUT_CYCLES  (16)
  ) u_b (
    .clock(clk), .reset(reset), .recheck(recheck),
    .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(waitrequest), .avm_readdata(readdata),
    .busy(b_busy), .done(b_done), .sysid_ok(b_ok),
    .id_mismatch(b_idm), .ts_mismatch(b_tsm), .timeout(b_to),
    .captured_id(b_cid), .captured_ts(b_cts)
  );

  // Slave model: stalls each read for stall_cfg cycles, or forever if stuck.
  logic [31:0] slv_id = 32'hE097_CBDC;
  logic [31:0] slv_ts = 32'h5767_F2DA;
  int          stall_cfg = 0;
  bit          stuck = 1'b0;
  int          stall_cnt = 0;

  assign waitrequest = stuck || (a_read && (stall_cnt < stall_cfg));
  assign readdata    = waitrequest ? 32'hBAD0_BAD0 : (a_addr ? slv_ts : slv_id);

  always @(posedge clk) begin
    if (reset)                    stall_cnt <= 0;
    else if (a_read && waitrequest) stall_cnt <= stall_cnt + 1;
    else                          stall_cnt <= 0;
  end

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    int          stall;
    logic        ok_a;
    logic        idm;
    logic        tsm_a;
    logic        ok_b;
    int          edges;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs until done (bounded). Counts edges, read cycles, addr-1 read cycles
  // and rising edges of the read strobe. ign>=0 injects a recheck pulse
  // that should land while busy.
  task automatic run_check(input bit pulse, input int ign, output int edges,
                           output int rd, output int rd1, output int rises);
    bit prev;
    edges = 0; rd = 0; rd1 = 0; rises = 0;
    prev = a_read;
    if (pulse) recheck = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (i == ign) recheck = 1'b1;
      else if ((pulse && i == 0) || (ign >= 0 && i == ign + 1)) recheck = 1'b0;
      if (a_read) begin
        rd++;
        if (a_addr) rd1++;
        if (!prev) rises++;
      end
      prev = a_read;
      if (a_done) break;
    end
    recheck = 1'b0;
    if (!a_done) begin
      total++;
      bad++;
      $display("FAIL done_wait actual=not_done required=done edges=%0d", edges);
    end
  endtask

  initial begin
    int e, rd, rd1, rs;
    bit rerun;

    vecs[0] = '{32'hE097_CBDC, 32'h5767_F2DA, 0, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vecs[1] = '{32'hDEAD_BEEF, 32'h5767_F2DA, 0, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[2] = '{32'hE097_CBDC, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b1, 1'b1, 5};
    vecs[3] = '{32'hE097_CBDC, 32'h5767_F2DA, 3, 1'b1, 1'b0, 1'b0, 1'b1, 11};
    vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 1, 1'b0, 1'b1, 1'b1, 1'b0, 7};

    // Reset state
    do_reset();
    chk("rst_ctrl", {28'd0, a_read, a_addr, a_busy, a_done}, 32'd0);
    chk("rst_flags", {28'd0, a_ok, a_idm, a_tsm, a_to}, 32'd0);
    chk("rst_cid", a_cid, 32'd0);
    chk("rst_cts", a_cts, 32'd0);

    // Table-driven checks, each from a fresh reset
    for (int v = 0; v < 5; v++) begin
      slv_id = vecs[v].id;
      slv_ts = vecs[v].ts;
      stall_cfg = vecs[v].stall;
      do_reset();
      run_check(1'b0, -1, e, rd, rd1, rs);
      chk($sformatf("v%0d_edges", v), e, vecs[v].edges);
      chk($sformatf("v%0d_rdcyc", v), rd, 2 * (vecs[v].stall + 1));
      chk($sformatf("v%0d_rd1cyc", v), rd1, vecs[v].stall + 1);
      chk($sformatf("v%0d_rises", v), rs, 1);
      chk($sformatf("v%0d_busy", v), a_busy, 1'b0);
      chk($sformatf("v%0d_ok_a", v), a_ok, vecs[v].ok_a);
      chk($sformatf("v%0d_idm", v), a_idm, vecs[v].idm);
      chk($sformatf("v%0d_tsm_a", v), a_tsm, vecs[v].tsm_a);
      chk($sformatf("v%0d_to", v), a_to, 1'b0);
      chk($sformatf("v%0d_cid", v), a_cid, vecs[v].id);
      chk($sformatf("v%0d_cts", v), a_cts, vecs[v].ts);
      chk($sformatf("v%0d_ok_b", v), b_ok, vecs[v].ok_b);
      chk($sformatf("v%0d_tsm_b", v), b_tsm, 1'b0);
      chk($sformatf("v%0d_idm_b", v), b_idm, vecs[v].idm);
    end

    // Timeout: good run, then stuck slave on recheck
    slv_id = 32'hE097_CBDC; slv_ts = 32'h5767_F2DA; stall_cfg = 0;
    do_reset();
    run_check(1'b0, -1, e, rd, rd1, rs);
    chk("pre_to_ok", a_ok, 1'b1);
    stuck = 1'b1;
    run_check(1'b1, -1, e, rd, rd1, rs);
    chk("to_edges", e, 19);
    chk("to_rdcyc", rd, 16);
    chk("to_rd1cyc", rd1, 0);
    chk("to_flag", a_to, 1'b1);
    chk("to_ok", a_ok, 1'b0);
    chk("to_cid_kept", a_cid, 32'hE097_CBDC);
    chk("to_read_low", a_read, 1'b0);
    stuck = 1'b0;
    run_check(1'b1, -1, e, rd, rd1, rs);
    chk("after_to_edges", e, 6);
    chk("after_to_ok", a_ok, 1'b1);
    chk("after_to_flag", a_to, 1'b0);

    // Recheck with wrong ID, plus a recheck while busy that must be ignored
    slv_id = 32'hDEAD_BEEF;
    recheck = 1'b1;
    @(posedge clk); #1;
    recheck = 1'b0;
    chk("rc_busy", a_busy, 1'b1);
    chk("rc_cleared", {29'd0, a_done, a_ok, a_idm}, 32'd0);
    run_check(1'b0, 2, e, rd, rd1, rs);
    chk("rc_edges", e, 5);
    chk("rc_idm", a_idm, 1'b1);
    chk("rc_ok", a_ok, 1'b0);
    chk("rc_cid", a_cid, 32'hDEAD_BEEF);
    rerun = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_busy || !a_done) rerun = 1'b1;
    end
    chk("busy_rc_ignored", rerun, 1'b0);

    // Reset during RD_TS
    slv_id = 32'hE097_CBDC; stall_cfg = 3;
    for (int i = 0; i < 40 && !(a_read && a_addr); i++) begin
      if (i == 0) recheck = 1'b1;
      @(posedge clk); #1;
      recheck = 1'b0;
    end
    chk("in_rd_ts", {31'd0, a_read && a_addr}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_read", a_read, 1'b0);
    chk("midrst_busy", a_busy, 1'b0);
    reset = 1'b0;
    run_check(1'b0, -1, e, rd, rd1, rs);
    chk("midrst_edges", e, 11);
    chk("midrst_ok", a_ok, 1'b1);

    // Reset coincident with recheck: reset wins, check runs once
    stall_cfg = 0;
    reset = 1'b1; recheck = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; recheck = 1'b0;
    chk("rstrc_done", a_done, 1'b0);
    run_check(1'b0, -1, e, rd, rd1, rs);
    chk("rstrc_edges", e, 5);
    chk("rstrc_ok", a_ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
